barcode_rx: RTL and testbench

- Receives the serial barcode stream read by the robot's optical sensor as it passes a station marker.
- Measures the start-bit width and uses it to decode 8 data bits, MSB first.
- Presents a valid station ID to the downstream command controller with a sticky valid flag.
- The flag is held until the command controller acknowledges it with clr_ID_vld.

---
 rtl/barcode_rx.sv | 166 ++++++++++++++++
 tb/tb_barcode_rx.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/barcode_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | barcode_rx: start-bit-timed serial barcode decoder with sticky station ID.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module barcode_rx #(
   parameter int CNT_W = 22
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       BC,
   output logic [7:0] ID,
   output logic       ID_vld,
   input  logic       clr_ID_vld
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      WAIT_FALL = 3'd2,
      SAMPLE    = 3'd3,
      DONE      = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_bc_ff1;
   logic             r_bc_s;
   logic             r_bc_q;
   logic [CNT_W-1:0] r_per_cnt;
   logic [CNT_W-1:0] r_period;
   logic [CNT_W-1:0] r_smp_cnt;
   logic [2:0]       r_bit_cnt;
   logic [7:0]       r_shift;
   logic [7:0]       r_id;
   logic             r_id_vld;

   logic w_fall;
   logic w_rise;
   logic w_per_clr;
   logic w_per_inc;
   logic w_per_latch;
   logic w_smp_clr;
   logic w_smp_inc;
   logic w_sample;
   logic w_load_id;

   assign w_fall = r_bc_q & ~r_bc_s;
   assign w_rise = ~r_bc_q & r_bc_s;
   assign ID     = r_id;
   assign ID_vld = r_id_vld;

   // Preset to 1 so an idle-high line produces no spurious edge out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bc_ff1 <= 1'b1;
         r_bc_s   <= 1'b1;
         r_bc_q   <= 1'b1;
      end else begin
         r_bc_ff1 <= BC;
         r_bc_s   <= r_bc_ff1;
         r_bc_q   <= r_bc_s;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_per_clr   = 1'b0;
      w_per_inc   = 1'b0;
      w_per_latch = 1'b0;
      w_smp_clr   = 1'b0;
      w_smp_inc   = 1'b0;
      w_sample    = 1'b0;
      w_load_id   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_fall) begin
               w_per_clr   = 1'b1;
               w_state_nxt = START;
            end
         end
         START: begin
            if (w_rise) begin
               w_per_latch = 1'b1;
               w_smp_clr   = 1'b1;
               w_state_nxt = WAIT_FALL;
            end else if (r_per_cnt == C_CNT_MAX) begin
               w_state_nxt = IDLE;
            end else if (!r_bc_s) begin
               w_per_inc = 1'b1;
            end
         end
         WAIT_FALL: begin
            if (w_fall) begin
               w_smp_clr   = 1'b1;
               w_state_nxt = SAMPLE;
            end else if (r_smp_cnt == C_CNT_MAX) begin
               w_state_nxt = IDLE;
            end else begin
               w_smp_inc = 1'b1;
            end
         end
         SAMPLE: begin
            // The sample point takes priority over a coincident edge.
            if (r_smp_cnt == r_period) begin
               w_sample    = 1'b1;
               w_smp_clr   = 1'b1;
               w_state_nxt = (r_bit_cnt == 3'd7) ? DONE : WAIT_FALL;
            end else if (w_fall) begin
               w_state_nxt = IDLE;
            end else begin
               w_smp_inc = 1'b1;
            end
         end
         DONE: begin
            w_load_id   = (r_shift[7:6] == 2'b00);
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_per_cnt <= '0;
         r_period  <= '0;
         r_smp_cnt <= '0;
         r_bit_cnt <= 3'd0;
         r_shift   <= 8'h00;
         r_id      <= 8'h00;
         r_id_vld  <= 1'b0;
      end else begin
         if (w_per_clr)      r_per_cnt <= '0;
         else if (w_per_inc) r_per_cnt <= r_per_cnt + 1'b1;

         if (w_per_latch) begin
            r_period  <= r_per_cnt;
            r_bit_cnt <= 3'd0;
         end else if (w_sample) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
         end

         if (w_smp_clr)      r_smp_cnt <= '0;
         else if (w_smp_inc) r_smp_cnt <= r_smp_cnt + 1'b1;

         if (w_sample) r_shift <= {r_shift[6:0], r_bc_s};

         // A new ID beats a same-cycle acknowledge so it is never lost.
         if (w_load_id) begin
            r_id     <= r_shift;
            r_id_vld <= 1'b1;
         end else if (clr_ID_vld) begin
            r_id_vld <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_barcode_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_barcode_rx: directed frame vectors for barcode_rx (CNT_W 22 and 8).      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_barcode_rx;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       bc_a = 1'b1;
   logic       bc_b = 1'b1;
   logic       clr_a = 1'b0;
   logic       clr_b = 1'b0;
   logic [7:0] id_a;
   logic [7:0] id_b;
   logic       vld_a;
   logic       vld_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   barcode_rx #(.CNT_W(22)) dut_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .BC        (bc_a),
      .ID        (id_a),
      .ID_vld    (vld_a),
      .clr_ID_vld(clr_a)
   );

   barcode_rx #(.CNT_W(8)) dut_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .BC        (bc_b),
      .ID        (id_b),
      .ID_vld    (vld_b),
      .clr_ID_vld(clr_b)
   );

   typedef struct {
      bit         sel;
      logic [7:0] data;
      int         t;
      int         per;
      int         gap;
      int         glitch;
      bit         clr_done;
      logic [7:0] exp_id;
      logic       exp_vld;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_bc(input bit sel, input logic v);
      if (sel) bc_b = v;
      else     bc_a = v;
   endtask

   task automatic set_clr(input bit sel, input logic v);
      if (sel) clr_b = v;
      else     clr_a = v;
   endtask

   // One data bit: falling edge, low T/2 (bit 1) or 2T (bit 0), then high.
   // pre/post capture ID_vld just before and just after the expected update.
   task automatic send_bit(input bit sel, input logic b, input int t, input int per,
                           input bit glitch, input bit clr_done,
                           output logic pre, output logic post);
      int   len;
      logic v;
      len  = b ? t / 2 : 2 * t;
      pre  = 1'b0;
      post = 1'b0;
      @(posedge clk); #1 set_bc(sel, 1'b0);
      for (int i = 1; i < per; i++) begin
         @(posedge clk); #1;
         if (i == t + 3) pre  = sel ? vld_b : vld_a;
         if (i == t + 4) post = sel ? vld_b : vld_a;
         v = (i >= len);
         if (glitch && i >= 40 && i < 43) v = ~v;
         set_bc(sel, v);
         set_clr(sel, clr_done && (i == t + 3));
      end
   endtask

   task automatic send_frame(input bit sel, input logic [7:0] data, input int t,
                             input int per, input int gap, input int nbits,
                             input int glitch_k, input bit clr_done,
                             output logic pre, output logic post);
      pre  = 1'b0;
      post = 1'b0;
      @(posedge clk); #1 set_bc(sel, 1'b0);
      repeat (t) @(posedge clk);
      #1 set_bc(sel, 1'b1);
      repeat (gap - 1) @(posedge clk);
      for (int k = 0; k < nbits; k++)
         send_bit(sel, data[7-k], t, per, (k == glitch_k), clr_done && (k == 7), pre, post);
   endtask

   initial begin
      logic pre;
      logic post;

      vecs[0] = '{1'b0, 8'hC5, 100, 300, 200, -1, 1'b0, 8'h2A, 1'b0};
      vecs[1] = '{1'b0, 8'h00, 100, 300, 200, -1, 1'b0, 8'h00, 1'b1};
      vecs[2] = '{1'b0, 8'h3F, 100, 300, 200, -1, 1'b0, 8'h3F, 1'b1};
      vecs[3] = '{1'b0, 8'h80, 100, 300, 200, -1, 1'b0, 8'h3F, 1'b1};
      vecs[4] = '{1'b0, 8'h2A, 100, 300, 200, -1, 1'b0, 8'h2A, 1'b1};
      vecs[5] = '{1'b0, 8'h15, 100, 300, 200, -1, 1'b1, 8'h15, 1'b1};
      vecs[6] = '{1'b1, 8'h11, 100, 300, 200, -1, 1'b0, 8'h11, 1'b1};
      vecs[7] = '{1'b1, 8'h2D, 100, 300, 200,  3, 1'b0, 8'h11, 1'b1};
      vecs[8] = '{1'b1, 8'h07, 100, 300, 200, -1, 1'b0, 8'h07, 1'b1};

      repeat (5) @(posedge clk);
      #1;
      check("reset_id_a", id_a, 8'h00);
      check("reset_vld_a", {7'd0, vld_a}, 8'h00);
      check("reset_id_b", id_b, 8'h00);
      check("reset_vld_b", {7'd0, vld_b}, 8'h00);
      rst_n = 1'b1;
      repeat (10) @(posedge clk);

      // 0x2A with exact two-clock latency, then acknowledge.
      send_frame(1'b0, 8'h2A, 100, 300, 200, 7, -1, 1'b0, pre, post);
      send_bit(1'b0, 1'b0, 100, 300, 1'b0, 1'b0, pre, post);
      check("lat_pre_vld", {7'd0, pre}, 8'h00);
      check("lat_post_vld", {7'd0, post}, 8'h01);
      check("first_id", id_a, 8'h2A);
      @(posedge clk); #1 clr_a = 1'b1;
      @(posedge clk); #1 clr_a = 1'b0;
      check("clr_vld", {7'd0, vld_a}, 8'h00);
      check("clr_id", id_a, 8'h2A);
      repeat (50) @(posedge clk);

      for (int n = 0; n < 9; n++) begin
         send_frame(vecs[n].sel, vecs[n].data, vecs[n].t, vecs[n].per, vecs[n].gap, 8,
                    vecs[n].glitch, vecs[n].clr_done, pre, post);
         repeat (400) @(posedge clk);
         #1;
         if (vecs[n].clr_done) check($sformatf("vec%0d_setwins", n), {7'd0, post}, 8'h01);
         check($sformatf("vec%0d_id", n), vecs[n].sel ? id_b : id_a, vecs[n].exp_id);
         check($sformatf("vec%0d_vld", n), {7'd0, vecs[n].sel ? vld_b : vld_a},
               {7'd0, vecs[n].exp_vld});
      end

      // Reset part-way through a frame, then a clean frame.
      send_frame(1'b0, 8'h3C, 100, 300, 200, 4, -1, 1'b0, pre, post);
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("midrst_id_a", id_a, 8'h00);
      check("midrst_vld_a", {7'd0, vld_a}, 8'h00);
      check("midrst_id_b", id_b, 8'h00);
      check("midrst_vld_b", {7'd0, vld_b}, 8'h00);
      bc_a  = 1'b1;
      rst_n = 1'b1;
      repeat (20) @(posedge clk);
      send_frame(1'b0, 8'h3F, 100, 300, 200, 8, -1, 1'b0, pre, post);
      repeat (400) @(posedge clk);
      #1;
      check("after_rst_id", id_a, 8'h3F);
      check("after_rst_vld", {7'd0, vld_a}, 8'h01);

      // Over-long start bit on the 8-bit counter instance times out.
      @(posedge clk); #1 bc_b = 1'b0;
      repeat (300) @(posedge clk);
      #1 bc_b = 1'b1;
      repeat (400) @(posedge clk);
      #1;
      check("timeout_vld", {7'd0, vld_b}, 8'h00);
      send_frame(1'b1, 8'h01, 50, 150, 100, 8, -1, 1'b0, pre, post);
      repeat (400) @(posedge clk);
      #1;
      check("post_timeout_id", id_b, 8'h01);
      check("post_timeout_vld", {7'd0, vld_b}, 8'h01);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
